div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 193 +++++++++++++++++++
 tb/tb_div_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the EX-stage divide issuer
// (master) and the iterative divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  // Requester side: drives operands and the start/annul controls.
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  // Divider side: consumes the request, returns {remainder, quotient}.
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per clock on magnitudes, sign fix-up on the last
// iteration. Result is {remainder, quotient} for the HI/LO write-back.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, requests with
// |dividend| < |divisor| finish in one cycle (q = 0, r = dividend).
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic               r_a_neg;
  logic               r_b_neg;
  logic [WIDTH-1:0]   r_b;        // divisor magnitude
  logic [2*WIDTH:0]   r_pr;       // {partial remainder (WIDTH+1), quotient (WIDTH)}
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  // Operand decode, valid in FREE when a request is presented.
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_zero;
  logic             w_accept;
  logic             w_early;

  assign w_a_neg    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_b_neg    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_abs_a    = w_a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_abs_b    = w_b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
  assign w_div_zero = (bus.opdata2_i == '0);
  assign w_accept   = (r_state == S_FREE) & bus.start_i & ~bus.annul_i;

`ifdef DIV_EARLY_OUT_EN
  // Quotient is trivially zero when the dividend magnitude is smaller.
  assign w_early = (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift, trial-subtract, keep or restore.
  logic [2*WIDTH:0] w_shift;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_ok;
  logic [2*WIDTH:0] w_pr_step;

  assign w_shift     = r_pr << 1;
  assign w_shift_rem = w_shift[2*WIDTH:WIDTH];
  // One extra bit so the borrow is exact even when the shifted remainder
  // uses its top bit.
  assign w_trial     = {1'b0, w_shift_rem} - {2'b00, r_b};
  assign w_trial_ok  = ~w_trial[WIDTH+1];
  assign w_pr_step   = w_trial_ok ? {w_trial[WIDTH:0], w_shift[WIDTH-1:1], 1'b1}
                                  : w_shift;

  // Sign fix-up applied to the result of the final iteration.
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_r_raw;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_last;

  assign w_q_raw = w_pr_step[WIDTH-1:0];
  assign w_r_raw = w_pr_step[2*WIDTH-1:WIDTH];
  assign w_q_fix = (r_signed & (r_a_neg ^ r_b_neg)) ? (~w_q_raw + 1'b1) : w_q_raw;
  assign w_r_fix = (r_signed & r_a_neg) ? (~w_r_raw + 1'b1) : w_r_raw;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) begin
          if (w_div_zero) begin
            w_state_next = S_BYZERO;
          end else if (w_early) begin
            w_state_next = S_END;
          end else begin
            w_state_next = S_ON;
          end
        end
      end
      S_BYZERO: begin
        w_state_next = bus.annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (bus.annul_i) begin
          w_state_next = S_FREE;
        end else if (w_last) begin
          w_state_next = S_END;
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          w_state_next = S_FREE;
        end
      end
      default: w_state_next = S_FREE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b      <= '0;
      r_pr     <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= (w_state_next == S_END);
      case (r_state)
        S_FREE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_signed <= bus.signed_div_i;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b      <= w_abs_b;
            if (w_div_zero) begin
              // Divide-by-zero reports the raw dividend as remainder.
              r_pr <= {{(WIDTH+1){1'b0}}, bus.opdata1_i};
            end else begin
              r_pr <= {{(WIDTH+1){1'b0}}, w_abs_a};
              if (w_early) begin
                r_result <= {bus.opdata1_i, {WIDTH{1'b0}}};
              end
            end
          end
        end
        S_BYZERO: begin
          if (!bus.annul_i) begin
            r_result <= {r_pr[WIDTH-1:0], {WIDTH{1'b1}}};
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            r_cnt <= '0;
          end else begin
            r_pr  <= w_pr_step;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_r_fix, w_q_fix};
            end
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            r_result <= '0;
            r_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  // Hold the issuing instruction until the result is available.
  assign bus.stallreq_o = bus.start_i & ~r_ready & ~rst;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table, corner-case sequences and randomized
// transactions against an arithmetic reference model for div_unit.
module tb_div_unit;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) dif ();

  div_unit #(.WIDTH(W), .CNT_W(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    q = sa / sb;
    r = sa % sb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return 2;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (sa < sb) return LAT_SMALL;
    return 33;
  endfunction

  // Present a request and count edges until ready; operands are scrambled
  // after acceptance since the divider must only sample them once.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output logic stall_ok);
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    stall_ok = 1'b1;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      #1;
      if (dif.stallreq_o !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      if (dif.ready_o === 1'b1) begin
        lat = n;
        break;
      end
      dif.opdata1_i    = $urandom;
      dif.opdata2_i    = $urandom;
      dif.signed_div_i = 1'($urandom);
    end
    res = dif.result_o;
  endtask

  task automatic drop_start(input string name);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " ready_clr"}, 64'(dif.ready_o), 64'd0);
    chk({name, " result_clr"}, dif.result_o, 64'd0);
  endtask

  task automatic idle_no_ready(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (dif.ready_o !== 1'b0) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic        stall_ok;
    logic [31:0] a, b;
    logic        s;

    vecs[0] = '{1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},               33,        "u100/7"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD},  33,        "s-7/2"};
    vecs[2] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0, 32'h80000000},         33,        "s_min/-1"};
    vecs[3] = '{1'b0, 32'd5,         32'd0,         {32'd5, 32'hFFFFFFFF},         2,         "u5/0"};
    vecs[4] = '{1'b0, 32'd3,         32'd10,        {32'd3, 32'd0},                LAT_SMALL, "u3/10"};
    vecs[5] = '{1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1, 32'hFFFFFFFD},         33,        "s7/-2"};
    vecs[6] = '{1'b1, 32'hFFFFFFF9,  32'd0,         {32'hFFFFFFF9, 32'hFFFFFFFF},  2,         "s-7/0"};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0, 32'hFFFFFFFF},         33,        "umax/1"};
    vecs[8] = '{1'b1, 32'hFFFFFFFD,  32'd10,        {32'hFFFFFFFD, 32'd0},         LAT_SMALL, "s-3/10"};
    vecs[9] = '{1'b0, 32'hFFFFFFF9,  32'd2,         {32'd1, 32'h7FFFFFFC},         33,        "u_big/2"};

    // Reset with a request pending: no stall, no result.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd9;
    dif.opdata2_i    = 32'd3;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stallreq", 64'(dif.stallreq_o), 64'd0);
    chk("reset ready", 64'(dif.ready_o), 64'd0);
    chk("reset result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].s, vecs[i].a, vecs[i].b, lat, res, stall_ok);
      chk({vecs[i].name, " lat"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, " result"}, res, vecs[i].res);
      chk({vecs[i].name, " stall"}, 64'(stall_ok), 64'd1);
      drop_start(vecs[i].name);
      @(posedge clk);
      #1;
    end

    // Hold start past ready: result stays put, then clears on release.
    do_div(1'b0, 32'd100, 32'd7, lat, res, stall_ok);
    chk("hold lat", 64'(lat), 64'd33);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold result", dif.result_o, {32'd2, 32'd14});
      chk("hold ready", 64'(dif.ready_o), 64'd1);
    end
    drop_start("hold");
    @(posedge clk);
    #1;

    // Annul at iteration 10 of 1000/3.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    idle_no_ready("annul no_ready", 40);
    do_div(1'b0, 32'd1000, 32'd3, lat, res, stall_ok);
    chk("after_annul lat", 64'(lat), 64'd33);
    chk("after_annul result", res, {32'd1, 32'd333});
    drop_start("after_annul");
    @(posedge clk);
    #1;

    // Annul while in the divide-by-zero state.
    dif.opdata1_i = 32'd5;
    dif.opdata2_i = 32'd0;
    dif.start_i   = 1'b1;
    @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    idle_no_ready("annul_byzero no_ready", 10);

    // Reset in the middle of an iteration.
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst ready", 64'(dif.ready_o), 64'd0);
    chk("midrst result", dif.result_o, 64'd0);
    chk("midrst stallreq", 64'(dif.stallreq_o), 64'd0);
    rst = 1'b0;
    dif.start_i = 1'b0;
    idle_no_ready("midrst no_ready", 40);

    // Start dropped mid-iteration: completes, then releases one cycle later.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    lat = -1;
    for (int n = 6; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (dif.ready_o === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("drop_in_on lat", 64'(lat), 64'd33);
    chk("drop_in_on result", dif.result_o, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    chk("drop_in_on ready_clr", 64'(dif.ready_o), 64'd0);
    chk("drop_in_on result_clr", dif.result_o, 64'd0);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        3: b = a >> $urandom_range(0, 8);
        default: begin
          b = $urandom;
          a = $urandom_range(0, 50);
        end
      endcase
      if (t == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
        s = 1'b1;
      end
      do_div(s, a, b, lat, res, stall_ok);
      chk($sformatf("rnd%0d s=%0d %h/%h lat", t, s, a, b), 64'(lat), 64'(ref_lat(s, a, b)));
      chk($sformatf("rnd%0d s=%0d %h/%h result", t, s, a, b), res, ref_div(s, a, b));
      dif.start_i = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d ready_clr", t), 64'(dif.ready_o), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
